opsum_ppu: RTL and testbench

- Post-processing unit directly downstream of the PE-array opsum path; consumes the 32-bit signed partial-sum stream that the pass controller writes back.
- Applies rounding right-shift requantisation, int8 saturation, optional ReLU and optional 2x2/stride-2 max-pool.
- Packs the int8 results four per 32-bit word for GLB write-back.
- Driven per tile by the op_config fields relu, maxpool and scale.

---
 rtl/ppu_pkg.sv | 34 +++
 rtl/ppu_quant.sv | 35 +++
 rtl/opsum_ppu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_opsum_ppu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types, constants and helpers for the opsum post-processing unit.
package ppu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] INT8_MIN  = 8'h80;
  localparam logic [7:0] INT8_MAX  = 8'h7F;
  localparam int         OUT_BYTES = 4;
  localparam int         SAT_W     = 64;

  // Per-sample routing decided when the opsum is accepted.
  typedef struct packed {
    logic first;  // first column of a horizontal pool pair
    logic store;  // pair max goes to the line buffer
    logic emit;   // sample produces an output byte
    logic last;   // final output byte of the frame
  } tag_t;

  function automatic logic [7:0] sat_int8(input logic signed [SAT_W-1:0] v);
    if (v > 64'sd127)       return INT8_MAX;
    else if (v < -64'sd128) return INT8_MIN;
    else                    return v[7:0];
  endfunction

  function automatic logic [7:0] smax8(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/ppu_quant.sv
// Combinational requantiser: rounding arithmetic right shift, int8 saturation, optional ReLU.
module ppu_quant
  import ppu_pkg::*;
#(
  parameter int PSUM_BITS = 32
) (
  input  logic [PSUM_BITS-1:0] x,
  input  logic [5:0]           scale,
  input  logic                 relu,
  output logic [7:0]           y,
  output logic                 sat
);

  localparam int EW = PSUM_BITS + 1;

  logic [4:0]              shamt;
  logic signed [EW-1:0]    x_ext;
  logic signed [EW-1:0]    bias;
  logic signed [EW-1:0]    y_wide;
  logic signed [SAT_W-1:0] y_ext;

  always_comb begin
    shamt = (scale > 6'd31) ? 5'd31 : scale[4:0];
    x_ext = $signed({x[PSUM_BITS-1], x});
    bias  = '0;
    if (shamt != 5'd0) bias[shamt - 5'd1] = 1'b1;
    // One extra bit keeps x + bias from wrapping near the top of the range.
    y_wide = (x_ext + bias) >>> shamt;
    y_ext  = SAT_W'(y_wide);
    sat    = (y_ext > 64'sd127) || (y_ext < -64'sd128);
    y      = sat_int8(y_ext);
    if (relu && y[7]) y = 8'h00;
  end

endmodule

// File: rtl/opsum_ppu.sv
// Opsum post-processing: requantise, optional 2x2 max-pool, pack int8 x4 per word.
// Build option: define PPU_SAT_CNT_EN to add the per-frame saturation counter output sat_cnt.
module opsum_ppu
  import ppu_pkg::*;
#(
  parameter int PSUM_BITS = 32,
  parameter int MAX_W     = 64,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic                 cfg_relu,
  input  logic                 cfg_maxpool,
  input  logic [5:0]           cfg_scale,
  input  logic [CNT_BITS-1:0]  cfg_row_len,
  input  logic [CNT_BITS-1:0]  cfg_rows,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PSUM_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
`ifdef PPU_SAT_CNT_EN
  ,
  output logic [15:0]          sat_cnt
`endif
);

  localparam int LB_N  = MAX_W / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  state_e              state_q, state_d;
  logic                relu_q, relu_d, pool_q, pool_d;
  logic [5:0]          scale_q, scale_d;
  logic [CNT_BITS-1:0] row_len_q, row_len_d, rows_q, rows_d;
  logic [CNT_BITS-1:0] row_q, row_d, col_q, col_d;
  logic                last_seen_q, last_seen_d;

  logic                q_valid_q, q_valid_d;
  logic [7:0]          q_byte_q, q_byte_d;
  tag_t                q_tag_q, q_tag_d;
  logic [LB_AW-1:0]    q_k_q, q_k_d;

  logic [7:0]          hold_q, hold_d;
  logic                p_valid_q, p_valid_d, p_last_q, p_last_d;
  logic [7:0]          p_byte_q, p_byte_d;

  logic [31:0]         pack_q, pack_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [31:0]         out_data_q, out_data_d;

  logic [7:0]          lbuf [LB_N];
  logic                lbuf_we;

  logic                adv, accept, last_in, zero_out, out_last_hs;
  logic [CNT_BITS-1:0] rows_ev, len_ev;
  logic [7:0]          qy, h, src_byte;
  logic                qsat, src_valid, src_last;
  logic [31:0]         merged;
  tag_t                tag_new;

  ppu_quant #(.PSUM_BITS(PSUM_BITS)) u_quant (
    .x     (in_data),
    .scale (scale_q),
    .relu  (relu_q),
    .y     (qy),
    .sat   (qsat)
  );

  // A stalled output word freezes every stage, so nothing is dropped or duplicated.
  assign adv         = !out_valid_q || out_ready;
  assign in_ready    = (state_q == ST_RUN) && adv;
  assign accept      = in_valid && in_ready;
  assign out_last_hs = out_valid_q && out_ready && out_last_q;
  assign rows_ev     = {rows_q[CNT_BITS-1:1], 1'b0};
  assign len_ev      = {row_len_q[CNT_BITS-1:1], 1'b0};
  assign last_in     = (row_q == rows_q - ONE) && (col_q == row_len_q - ONE);
  assign zero_out    = pool_q && ((rows_ev == '0) || (len_ev == '0));
  assign h           = smax8(hold_q, q_byte_q);
  assign src_valid   = pool_q ? p_valid_q : (q_valid_q && q_tag_q.emit);
  assign src_byte    = pool_q ? p_byte_q  : q_byte_q;
  assign src_last    = pool_q ? p_last_q  : q_tag_q.last;
  assign merged      = pack_q | (32'(src_byte) << {cnt_q, 3'b000});

  always_comb begin
    tag_new = '0;
    if (pool_q) begin
      tag_new.first = !col_q[0];
      tag_new.store = col_q[0] && !row_q[0] && (row_q != rows_q - ONE);
      tag_new.emit  = col_q[0] && row_q[0];
      tag_new.last  = tag_new.emit && (row_q == rows_ev - ONE) && (col_q == len_ev - ONE);
    end else begin
      tag_new.emit  = 1'b1;
      tag_new.last  = last_in;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d     = state_q;
    relu_d      = relu_q;
    pool_d      = pool_q;
    scale_d     = scale_q;
    row_len_d   = row_len_q;
    rows_d      = rows_q;
    row_d       = row_q;
    col_d       = col_q;
    last_seen_d = last_seen_q || out_last_hs;
    q_valid_d   = q_valid_q;
    q_byte_d    = q_byte_q;
    q_tag_d     = q_tag_q;
    q_k_d       = q_k_q;
    hold_d      = hold_q;
    p_valid_d   = p_valid_q;
    p_byte_d    = p_byte_q;
    p_last_d    = p_last_q;
    pack_d      = pack_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    lbuf_we     = 1'b0;

    if (adv) begin
      q_valid_d = accept;
      if (accept) begin
        q_byte_d = qy;
        q_tag_d  = tag_new;
        q_k_d    = LB_AW'(col_q >> 1);
      end

      p_valid_d = 1'b0;
      if (q_valid_q && pool_q) begin
        if (q_tag_q.first) hold_d = q_byte_q;
        lbuf_we = q_tag_q.store;
        if (q_tag_q.emit) begin
          p_valid_d = 1'b1;
          p_byte_d  = smax8(h, lbuf[q_k_q]);
          p_last_d  = q_tag_q.last;
        end
      end

      out_valid_d = 1'b0;
      if (src_valid) begin
        if (src_last || (cnt_q == 2'(OUT_BYTES - 1))) begin
          out_valid_d = 1'b1;
          out_data_d  = merged;
          out_last_d  = src_last;
          pack_d      = '0;
          cnt_d       = '0;
        end else begin
          pack_d = merged;
          cnt_d  = cnt_q + 2'd1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          relu_d      = cfg_relu;
          pool_d      = cfg_maxpool;
          scale_d     = cfg_scale;
          row_len_d   = cfg_row_len;
          rows_d      = cfg_rows;
          row_d       = '0;
          col_d       = '0;
          last_seen_d = 1'b0;
          pack_d      = '0;
          cnt_d       = '0;
          state_d     = ((cfg_row_len == '0) || (cfg_rows == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (col_q == row_len_q - ONE) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
          if (last_in) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last word can handshake while trailing dropped inputs are still arriving.
        if (zero_out || last_seen_q || out_last_hs) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      relu_q      <= 1'b0;
      pool_q      <= 1'b0;
      scale_q     <= '0;
      row_len_q   <= '0;
      rows_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      last_seen_q <= 1'b0;
      q_valid_q   <= 1'b0;
      q_byte_q    <= '0;
      q_tag_q     <= '0;
      q_k_q       <= '0;
      hold_q      <= '0;
      p_valid_q   <= 1'b0;
      p_byte_q    <= '0;
      p_last_q    <= 1'b0;
      pack_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      relu_q      <= relu_d;
      pool_q      <= pool_d;
      scale_q     <= scale_d;
      row_len_q   <= row_len_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      col_q       <= col_d;
      last_seen_q <= last_seen_d;
      q_valid_q   <= q_valid_d;
      q_byte_q    <= q_byte_d;
      q_tag_q     <= q_tag_d;
      q_k_q       <= q_k_d;
      hold_q      <= hold_d;
      p_valid_q   <= p_valid_d;
      p_byte_q    <= p_byte_d;
      p_last_q    <= p_last_d;
      pack_q      <= pack_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the line buffer has no reset; every odd-row read follows an even-row write in the same frame.
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf[q_k_q] <= h;
  end

`ifdef PPU_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if ((state_q == ST_IDLE) && cfg_load)                sat_cnt_d = '0;
    else if (accept && qsat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_opsum_ppu.sv
// Scoreboard bench for opsum_ppu: expected words queued at stimulus time, popped on output handshake.
module tb_opsum_ppu;

  logic        clk = 1'b0;
  logic        rst, cfg_load, cfg_relu, cfg_maxpool;
  logic [5:0]  cfg_scale;
  logic [7:0]  cfg_row_len, cfg_rows;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last, busy, done;
`ifdef PPU_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  exp_bytes[$];
  int          stim[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          v_rise_cyc = 0;
  bit          bp_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data = '0;

  opsum_ppu dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_relu    (cfg_relu),
    .cfg_maxpool (cfg_maxpool),
    .cfg_scale   (cfg_scale),
    .cfg_row_len (cfg_row_len),
    .cfg_rows    (cfg_rows),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef PPU_SAT_CNT_EN
    ,
    .sat_cnt     (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? ((cyc % 3) == 0) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability, valid-rise timestamp.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", out_data, prev_data);
      end
      if (out_valid && !prev_valid) v_rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_word", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("word_data", out_data, e.data);
          check("word_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  function automatic logic [7:0] qref(input int x, input int scale, input bit relu);
    longint y;
    int     s;
    s = (scale > 31) ? 31 : scale;
    y = longint'(x);
    if (s != 0) y = (y + (longint'(1) <<< (s - 1))) >>> s;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    if (relu && (y < 0)) y = 0;
    return 8'(y);
  endfunction

  task automatic push_word(input logic [31:0] w, input logic last);
    exp_t e;
    e.data = w;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic flush_expected();
    logic [31:0] w;
    int          n;
    w = '0;
    n = 0;
    for (int i = 0; i < exp_bytes.size(); i++) begin
      w[8*n +: 8] = exp_bytes[i];
      n++;
      if ((n == 4) || (i == exp_bytes.size() - 1)) begin
        push_word(w, i == exp_bytes.size() - 1);
        w = '0;
        n = 0;
      end
    end
    exp_bytes.delete();
  endtask

  task automatic start_frame(input bit relu, input bit pool, input int scale, input int len, input int rows);
    cfg_relu    = relu;
    cfg_maxpool = pool;
    cfg_scale   = 6'(scale);
    cfg_row_len = 8'(len);
    cfg_rows    = 8'(rows);
    cfg_load    = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic send(input int x);
    bit   ok;
    logic hs;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'(x);
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("in_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input bit relu, input bit pool, input int scale,
                           input int len, input int rows);
    start_frame(relu, pool, scale, len, rows);
    foreach (stim[i]) send(stim[i]);
    wait_done(tag);
  endtask

  task automatic model_frame(input int scale, input bit relu);
    foreach (stim[i]) exp_bytes.push_back(qref(stim[i], scale, relu));
    flush_expected();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cfg_load    = 1'b0;
    cfg_relu    = 1'b0;
    cfg_maxpool = 1'b0;
    cfg_scale   = '0;
    cfg_row_len = '0;
    cfg_rows    = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", {26'd0, in_ready, out_valid, out_last, busy, done, 1'b0}, 32'd0);
    check("rst_data", out_data, 32'd0);
    @(posedge clk);
    #1;

    // Rounding shift with one saturated value.
    push_word(32'h7FFF0201, 1'b1);
    stim = '{5, 6, -6, 1000};
    run_frame("scale", 1'b0, 1'b0, 2, 4, 1);
    check("lat_nopool", 32'(v_rise_cyc - (acc_cyc - 1)), 32'd2);
`ifdef PPU_SAT_CNT_EN
    check("sat_cnt_scale", 32'(sat_cnt), 32'd1);
`endif

    // ReLU and a trailing partial word.
    push_word(32'h07000400, 1'b0);
    push_word(32'h00000009, 1'b1);
    stim = '{-3, 4, -128, 7, 9};
    run_frame("relu", 1'b1, 1'b0, 0, 5, 1);
`ifdef PPU_SAT_CNT_EN
    check("sat_cnt_relu", 32'(sat_cnt), 32'd0);
`endif

    // 2x2 max-pool.
    push_word(32'h00000805, 1'b1);
    stim = '{1, 5, -2, 3, 4, 0, 8, -9};
    run_frame("pool", 1'b0, 1'b1, 0, 4, 2);
    check("lat_pool", 32'(v_rise_cyc - (acc_cyc - 1)), 32'd3);

    // Odd dimensions: trailing column and row consumed but dropped.
    push_word(32'h00000001, 1'b1);
    stim = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_frame("odd", 1'b0, 1'b1, 0, 3, 3);

    // Same 16 inputs without and with output backpressure.
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(int'($urandom_range(4000, 0)) - 2000);
    model_frame(4, 1'b0);
    run_frame("nostall", 1'b0, 1'b0, 4, 8, 2);
    model_frame(4, 1'b0);
    bp_en = 1'b1;
    run_frame("stall", 1'b0, 1'b0, 4, 8, 2);
    bp_en = 1'b0;

    // Wide random values: saturation, rounding and ReLU together.
    stim.delete();
    for (int i = 0; i < 15; i++) stim.push_back(int'($urandom_range(400000, 0)) - 200000);
    model_frame(7, 1'b1);
    run_frame("rand", 1'b1, 1'b0, 7, 5, 3);

    // Zero-size frame goes straight to DONE.
    stim.delete();
    run_frame("empty", 1'b0, 1'b0, 0, 0, 3);

    // Reset in the middle of a frame.
    start_frame(1'b0, 1'b0, 0, 8, 1);
    send(10);
    send(20);
    send(30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_outs", {28'd0, in_ready, out_valid, out_last, busy}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    rst = 1'b0;
    push_word(32'h7FFF0201, 1'b1);
    stim = '{5, 6, -6, 1000};
    run_frame("after_rst", 1'b0, 1'b0, 2, 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
